// File: rtl/segment_pkg.sv
// segment_pkg: shared definitions for the segment scan controller.
//   - SEG_DASH / SEG_BLANK segment patterns (a..g in bits 0..6)
//   - FSM state encodings IDLE / CONV / LOAD
//   - seg_font(): 4-bit nibble -> 7-segment pattern (0-9, A, b, C, d, E, F)
package segment_pkg;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    function automatic logic [6:0] seg_font(input logic [3:0] nibble);
        logic [6:0] pattern;
        unique case (nibble)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            4'hF: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/segment_scan_ctrl_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble binary -> BCD converter.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   start_in        loads value_in and begins a WIDTH-step conversion
//   value_in        binary input
//   done_out        high during the final step; bcd_out is final the cycle after
//   bcd_out         DIGITS packed BCD nibbles, digit 0 in bits [3:0]
//   overflow_out    sticky: a 1 was shifted out of the top nibble
module bin2bcd_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [WIDTH-1:0]      value_in,
    output logic                  done_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    shift_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt_q;

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (start_in) begin
            shift_q <= value_in;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            shift_q <= shift_q << 1;
            bcd_q   <= {bcd_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
            ovf_q   <= ovf_q | bcd_adj[4*DIGITS-1];
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    assign done_out     = (cnt_q == CNT_W'(1));
    assign bcd_out      = bcd_q;
    assign overflow_out = ovf_q;

endmodule

// File: rtl/segment_scan_ctrl.sv
// segment_scan_ctrl: time-multiplexed 7-segment display controller.
// Accepts a binary value over valid/ready, converts it to BCD (or shows raw hex) and scans
// DIGITS digits over one shared segment bus with one-hot digit selects.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   value_in         binary value; hex_mode_in / dp_in sampled alongside it
//   valid_in         input valid; ready_out high when a new value can be accepted
//   seg_out          a..g in bits 0..6, dp in bit 7
//   dig_sel_out      one-hot active digit
//   overflow_out     displayed value did not fit in DIGITS digits
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros in decimal mode.
module segment_scan_ctrl
    import segment_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int WIDTH          = 12,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [WIDTH-1:0]  value_in,
    input  logic              hex_mode_in,
    input  logic [DIGITS-1:0] dp_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] dig_sel_out,
    output logic              overflow_out
);

    localparam int PAD_W = (WIDTH > 4*DIGITS) ? WIDTH : 4*DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [1:0]               state_q;
    logic [WIDTH-1:0]         val_q;
    logic                     hex_q;
    logic [DIGITS-1:0]        dp_cap_q;

    // Display registers, only ever written in LOAD.
    logic [DIGITS-1:0][3:0]   digit_q;
    logic [DIGITS-1:0]        blank_q;
    logic [DIGITS-1:0]        dp_q;
    logic                     ovf_q;

    logic [PRE_W-1:0]         pre_q;
    logic [IDX_W-1:0]         idx_q;
    logic [7:0]               seg_q;
    logic [DIGITS-1:0]        sel_q;

    logic                     accept;
    logic                     conv_start;
    logic                     conv_done;
    logic [4*DIGITS-1:0]      conv_bcd;
    logic                     conv_ovf;

    logic [PAD_W-1:0]         val_pad;
    logic [DIGITS-1:0][3:0]   load_digits;
    logic                     load_ovf;
    logic [DIGITS-1:0]        load_blank;
    logic [6:0]               seg_pattern;

    assign ready_out  = (state_q == IDLE);
    assign accept     = ready_out && valid_in;
    assign conv_start = accept && !hex_mode_in;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (conv_start),
        .value_in     (value_in),
        .done_out     (conv_done),
        .bcd_out      (conv_bcd),
        .overflow_out (conv_ovf)
    );

    // Digits, overflow and blank mask to be copied into the display in LOAD.
    always_comb begin
        val_pad = PAD_W'(val_q);
        if (hex_q) begin
            load_digits = val_pad[4*DIGITS-1:0];
            load_ovf    = |(val_pad >> (4*DIGITS));
        end else begin
            load_digits = conv_bcd;
            load_ovf    = conv_ovf;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;

    always_comb begin
        load_blank = '0;
        lead_zero  = !hex_q && !load_ovf;
        // Walk from the top digit down; digit 0 is never blanked.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead_zero && (load_digits[k] == 4'd0)) begin
                load_blank[k] = 1'b1;
            end else begin
                lead_zero = 1'b0;
            end
        end
    end
`else
    assign load_blank = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            val_q    <= '0;
            hex_q    <= 1'b0;
            dp_cap_q <= '0;
            digit_q  <= '0;
            blank_q  <= '0;
            dp_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        val_q    <= value_in;
                        hex_q    <= hex_mode_in;
                        dp_cap_q <= dp_in;
                        state_q  <= hex_mode_in ? LOAD : CONV;
                    end
                end
                CONV: begin
                    // done marks the last step; the BCD result is final in LOAD.
                    if (conv_done) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    digit_q <= load_digits;
                    blank_q <= load_blank;
                    dp_q    <= dp_cap_q;
                    ovf_q   <= load_ovf;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        if (ovf_q) begin
            seg_pattern = SEG_DASH;
        end else if (blank_q[idx_q]) begin
            seg_pattern = SEG_BLANK;
        end else begin
            seg_pattern = seg_font(digit_q[idx_q]);
        end
    end

    // Free-running scan, independent of the conversion FSM.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= '0;
            sel_q <= '0;
        end else begin
            if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
            seg_q <= {dp_q[idx_q], seg_pattern};
            sel_q <= DIGITS'(1) << idx_q;
        end
    end

    // Polarity applied after the registers so reset reads as all-off at the pins.
    assign seg_out      = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dig_sel_out  = (SEG_ACTIVE_LOW != 0) ? ~sel_q : sel_q;
    assign overflow_out = ovf_q;

endmodule
